// File: rtl/toy_bus_arb_node_lsu_req_pkg.sv
// Shared ToyBusReq definitions: default field widths, payload layout and the
// 2:1 round-robin grant helper used by the arbiter.
package toy_bus_arb_node_lsu_req_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_STRB_W = 32;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_ID_W   = 4;
  localparam int DEF_SB_W   = 10;

  localparam int DEF_REQ_W  = DEF_ADDR_W + DEF_STRB_W + DEF_DATA_W + 1
                            + DEF_ID_W + DEF_ID_W + DEF_SB_W;

  // Field order matches the flat payload concat used inside the arbiter node.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_STRB_W-1:0] strb;
    logic [DEF_DATA_W-1:0] data;
    logic                  opcode;
    logic [DEF_ID_W-1:0]   src_id;
    logic [DEF_ID_W-1:0]   tgt_id;
    logic [DEF_SB_W-1:0]   sideband;
  } toy_bus_req_t;

  localparam logic PTR_IN0 = 1'b0;
  localparam logic PTR_IN1 = 1'b1;

  // One-hot grant; with both requesting, ptr names the input that wins.
  function automatic logic [1:0] rr_grant2(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = req;
    if (&req) begin
      gnt = (ptr == PTR_IN1) ? 2'b10 : 2'b01;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/toy_bus_arb_node_lsu_req_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant plus the priority
// pointer, which flips to the losing side on every accepted request.
module toy_bus_rr_arb2
  import toy_bus_arb_node_lsu_req_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       free_i,
  output logic [1:0] gnt_o
);

  logic ptr_d;
  logic ptr_q;

  assign gnt_o = rr_grant2(req_i, ptr_q);

  // A granted request is always accepted when the stage is free, so any
  // request while free means a handshake this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (free_i && (|req_i)) begin
      ptr_d = ~gnt_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_IN0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/toy_bus_arb_node_lsu_req.sv
// 2:1 round-robin merge of ToyBusReq sources into one registered output stage
// (1-cycle latency, full throughput, ready never depends combinationally on out_vld->in_vld).
module toy_bus_arb_node_lsu_req
  import toy_bus_arb_node_lsu_req_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STRB_W = DEF_STRB_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W,
  parameter int SB_W   = DEF_SB_W
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [STRB_W-1:0] in0_strb,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_opcode,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  input  logic [SB_W-1:0]   in0_sideband,

  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [STRB_W-1:0] in1_strb,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_opcode,
  input  logic [ID_W-1:0]   in1_src_id,
  input  logic [ID_W-1:0]   in1_tgt_id,
  input  logic [SB_W-1:0]   in1_sideband,

  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ADDR_W-1:0] out_addr,
  output logic [STRB_W-1:0] out_strb,
  output logic [DATA_W-1:0] out_data,
  output logic              out_opcode,
  output logic [ID_W-1:0]   out_src_id,
  output logic [ID_W-1:0]   out_tgt_id,
  output logic [SB_W-1:0]   out_sideband
);

  localparam int REQ_W = ADDR_W + STRB_W + DATA_W + 1 + ID_W + ID_W + SB_W;

  logic [REQ_W-1:0] in0_req;
  logic [REQ_W-1:0] in1_req;
  logic [REQ_W-1:0] sel_req;
  logic [REQ_W-1:0] req_d;
  logic [REQ_W-1:0] req_q;
  logic             out_vld_d;
  logic             out_vld_q;
  logic             free;
  logic             load;
  logic [1:0]       gnt;

  assign in0_req = {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband};
  assign in1_req = {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband};

  // Stage can take a new request when empty or being emptied this cycle.
  assign free = !out_vld_q || out_rdy;

  toy_bus_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  ({in1_vld, in0_vld}),
    .free_i (free),
    .gnt_o  (gnt)
  );

  assign in0_rdy = free && gnt[0];
  assign in1_rdy = free && gnt[1];
  assign load    = (in0_vld && in0_rdy) || (in1_vld && in1_rdy);

  always_comb begin
    sel_req   = gnt[1] ? in1_req : in0_req;
    out_vld_d = out_vld_q;
    req_d     = req_q;
    if (free) begin
      out_vld_d = load;
      if (load) begin
        req_d = sel_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      req_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      req_q     <= req_d;
    end
  end

  assign out_vld = out_vld_q;
  assign {out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id, out_sideband} = req_q;

endmodule
